// File: rtl/decode_ibuf.sv
// Instruction buffer between fetch1 and decode: a DEPTH-entry circular queue of
// {exc, pc, insn} with pre-decoded branch/JAL hints. Optional macro DECODE_IBUF_BYPASS_EN.
module decode_ibuf #(
  parameter int DEPTH       = 4,
  parameter int STALL_SLACK = 1
) (
  input  logic                   clk_core,
  input  logic                   reset_n,
  input  logic                   fe1_valid,
  input  logic                   fe1_exc,
  input  logic [31:2]            fe1_pc,
  input  logic [31:0]            fe1_insn,
  output logic                   ibuf_stall,
  input  logic                   flush,
  input  logic                   de_stall,
  output logic                   ibuf_valid,
  output logic                   ibuf_exc,
  output logic [31:2]            ibuf_pc,
  output logic [31:0]            ibuf_insn,
  output logic                   ibuf_br_back,
  output logic                   ibuf_jal,
  output logic [$clog2(DEPTH):0] ibuf_count,
  output logic                   ibuf_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_SLACK);

  logic          exc_q  [DEPTH];
  logic [31:2]   pc_q   [DEPTH];
  logic [31:0]   insn_q [DEPTH];
  logic          br_q   [DEPTH];
  logic          jal_q  [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic stored_valid, full, push, pop, bypass_take, push_acc;
  logic fe1_br_back, fe1_jal;

  // Hints are suppressed on faulted fetches so decode never redirects on garbage.
  assign fe1_br_back = ~fe1_exc & (fe1_insn[6:0] == 7'b1100011) & fe1_insn[31];
  assign fe1_jal     = ~fe1_exc & (fe1_insn[6:0] == 7'b1101111);

  always_comb begin
    stored_valid = (count_q != '0);
    full         = (count_q == DEPTH_C);
    push         = fe1_valid & ~flush;
    pop          = stored_valid & ~de_stall & ~flush;
    bypass_take  = 1'b0;
`ifdef DECODE_IBUF_BYPASS_EN
    bypass_take  = ~stored_valid & push & ~de_stall;
`endif
    push_acc     = push & ~bypass_take & (~full | pop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only observable while count covers them.
  always_ff @(posedge clk_core) begin
    if (push_acc) begin
      exc_q[wr_ptr_q]  <= fe1_exc;
      pc_q[wr_ptr_q]   <= fe1_pc;
      insn_q[wr_ptr_q] <= fe1_insn;
      br_q[wr_ptr_q]   <= fe1_br_back;
      jal_q[wr_ptr_q]  <= fe1_jal;
    end
  end

  always_comb begin
    ibuf_valid   = 1'b0;
    ibuf_exc     = 1'b0;
    ibuf_pc      = '0;
    ibuf_insn    = '0;
    ibuf_br_back = 1'b0;
    ibuf_jal     = 1'b0;
    if (stored_valid) begin
      ibuf_valid   = 1'b1;
      ibuf_exc     = exc_q[rd_ptr_q];
      ibuf_pc      = pc_q[rd_ptr_q];
      ibuf_insn    = insn_q[rd_ptr_q];
      ibuf_br_back = br_q[rd_ptr_q];
      ibuf_jal     = jal_q[rd_ptr_q];
    end
`ifdef DECODE_IBUF_BYPASS_EN
    else if (push) begin
      ibuf_valid   = 1'b1;
      ibuf_exc     = fe1_exc;
      ibuf_pc      = fe1_pc;
      ibuf_insn    = fe1_insn;
      ibuf_br_back = fe1_br_back;
      ibuf_jal     = fe1_jal;
    end
`endif
  end

  assign ibuf_stall    = (count_q >= STALL_TH);
  assign ibuf_count    = count_q;
  assign ibuf_overflow = ovf_q;

endmodule

// File: tb/tb_decode_ibuf.sv
// Self-checking bench for decode_ibuf: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_decode_ibuf;
  localparam int DEPTH = 4;
  localparam int SLACK = 1;
`ifdef DECODE_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_core = 1'b0;
  logic        reset_n  = 1'b0;
  logic        fe1_valid = 1'b0, fe1_exc = 1'b0, flush = 1'b0, de_stall = 1'b0;
  logic [29:0] fe1_pc = '0;
  logic [31:0] fe1_insn = '0;
  logic        ibuf_stall, ibuf_valid, ibuf_exc, ibuf_br_back, ibuf_jal, ibuf_overflow;
  logic [29:0] ibuf_pc;
  logic [31:0] ibuf_insn;
  logic [2:0]  ibuf_count;

  decode_ibuf #(.DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .fe1_valid(fe1_valid), .fe1_exc(fe1_exc), .fe1_pc(fe1_pc), .fe1_insn(fe1_insn),
    .ibuf_stall(ibuf_stall), .flush(flush), .de_stall(de_stall),
    .ibuf_valid(ibuf_valid), .ibuf_exc(ibuf_exc), .ibuf_pc(ibuf_pc), .ibuf_insn(ibuf_insn),
    .ibuf_br_back(ibuf_br_back), .ibuf_jal(ibuf_jal),
    .ibuf_count(ibuf_count), .ibuf_overflow(ibuf_overflow)
  );

  // Clock / watchdog
  always #5 clk_core = ~clk_core;

  int checks   = 0;
  int failures = 0;

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Scoreboard: in-order expected entries {exc, pc, insn}
  logic [62:0] exp_q[$];
  logic        mdl_ovf = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic hint_br(input logic e, input logic [31:0] i);
    return !e && i[6:0] == 7'h63 && i[31];
  endfunction
  function automatic logic hint_jal(input logic e, input logic [31:0] i);
    return !e && i[6:0] == 7'h6F;
  endfunction

  // Driver: apply inputs at posedge+1, compare to model at negedge, then advance model.
  task automatic cycle(input logic v, input logic e, input logic [29:0] pc,
                       input logic [31:0] insn, input logic f, input logic ds);
    logic [62:0] head;
    logic        hv, byp, pop, room;
    fe1_valid = v; fe1_exc = e; fe1_pc = pc; fe1_insn = insn; flush = f; de_stall = ds;
    #4;
    hv   = (exp_q.size() != 0);
    head = hv ? exp_q[0] : '0;
    byp  = 1'b0;
    if (BYP && !hv && v && !f) begin
      byp = 1'b1; hv = 1'b1; head = {e, pc, insn};
    end
    chk("mdl_valid", ibuf_valid, hv);
    chk("mdl_exc",   ibuf_exc,   head[62]);
    chk("mdl_pc",    ibuf_pc,    head[61:32]);
    chk("mdl_insn",  ibuf_insn,  head[31:0]);
    chk("mdl_br",    ibuf_br_back, hint_br(head[62], head[31:0]));
    chk("mdl_jal",   ibuf_jal,     hint_jal(head[62], head[31:0]));
    chk("mdl_count", ibuf_count, 64'(exp_q.size()));
    chk("mdl_stall", ibuf_stall, exp_q.size() >= DEPTH - SLACK);
    chk("mdl_ovf",   ibuf_overflow, mdl_ovf);
    if (f) begin
      exp_q.delete();
    end else begin
      pop  = (exp_q.size() != 0) && !ds;
      room = (exp_q.size() < DEPTH) || pop;
      if (pop) void'(exp_q.pop_front());
      if (v && !(byp && !ds)) begin
        if (room) exp_q.push_back({e, pc, insn});
        else      mdl_ovf = 1'b1;
      end
    end
    @(posedge clk_core); #1;
  endtask

  task automatic idle(input logic ds);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, ds);
  endtask

  typedef struct {
    logic v; logic [29:0] pc; logic f; logic ds;
    logic ev; logic [29:0] epc; logic [2:0] ecnt; logic est; logic eov;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [29:0] pc, input logic f,
                              input logic ds, input logic ev, input logic [29:0] epc,
                              input logic [2:0] ecnt, input logic est, input logic eov);
    vec_t r;
    r.v = v; r.pc = pc; r.f = f; r.ds = ds;
    r.ev = ev; r.epc = epc; r.ecnt = ecnt; r.est = est; r.eov = eov;
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (3) @(posedge clk_core);
    #1;
    chk("rst_valid", ibuf_valid, 0);
    chk("rst_count", ibuf_count, 0);
    chk("rst_ovf",   ibuf_overflow, 0);
    chk("rst_stall", ibuf_stall, 0);
    reset_n = 1'b1;
    @(posedge clk_core); #1;

    // Table: fill to overflow, pop, flush, refill. Expected values seen during the row.
    tbl[0]  = mk(1, 30'h400, 0, 1, BYP, BYP ? 30'h400 : 30'h0, 0, 0, 0);
    tbl[1]  = mk(1, 30'h401, 0, 1, 1, 30'h400, 1, 0, 0);
    tbl[2]  = mk(1, 30'h402, 0, 1, 1, 30'h400, 2, 0, 0);
    tbl[3]  = mk(1, 30'h403, 0, 1, 1, 30'h400, 3, 1, 0);
    tbl[4]  = mk(1, 30'h404, 0, 1, 1, 30'h400, 4, 1, 0);
    tbl[5]  = mk(0, 30'h0,   0, 1, 1, 30'h400, 4, 1, 1);
    tbl[6]  = mk(0, 30'h0,   0, 0, 1, 30'h400, 4, 1, 1);
    tbl[7]  = mk(0, 30'h0,   0, 1, 1, 30'h401, 3, 1, 1);
    tbl[8]  = mk(1, 30'h7FF, 1, 0, 1, 30'h401, 3, 1, 1);
    tbl[9]  = mk(0, 30'h0,   0, 1, 0, 30'h0,   0, 0, 1);
    tbl[10] = mk(1, 30'h500, 0, 1, BYP, BYP ? 30'h500 : 30'h0, 0, 0, 1);
    tbl[11] = mk(0, 30'h0,   0, 0, 1, 30'h500, 1, 0, 1);
    tbl[12] = mk(0, 30'h0,   0, 1, 0, 30'h0,   0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      fe1_valid = tbl[i].v; fe1_exc = 1'b0; fe1_pc = tbl[i].pc; fe1_insn = 32'h13;
      flush = tbl[i].f; de_stall = tbl[i].ds;
      #3;
      chk($sformatf("tbl%0d_valid", i), ibuf_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i),    ibuf_pc,    tbl[i].epc);
      chk($sformatf("tbl%0d_count", i), ibuf_count, tbl[i].ecnt);
      chk($sformatf("tbl%0d_stall", i), ibuf_stall, tbl[i].est);
      chk($sformatf("tbl%0d_ovf", i),   ibuf_overflow, tbl[i].eov);
      #1;
      cycle(tbl[i].v, 1'b0, tbl[i].pc, 32'h13, tbl[i].f, tbl[i].ds);
    end

    // Reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 30'h100 + 30'(i), 32'h13, 1'b0, 1'b1);
    fe1_valid = 1'b0; de_stall = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", ibuf_valid, 0);
    chk("midrst_count", ibuf_count, 0);
    chk("midrst_ovf",   ibuf_overflow, 0);
    exp_q.delete();
    mdl_ovf = 1'b0;
    @(posedge clk_core); #1;
    reset_n = 1'b1;
    @(posedge clk_core); #1;
    cycle(1'b1, 1'b0, 30'h123, 32'h13, 1'b0, 1'b1);
    chk("post_rst_pc", ibuf_pc, 30'h123);
    idle(1'b0);

    // Full buffer, simultaneous push and pop, pointers wrap twice
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 30'h600 + 30'(i), 32'h13, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 30'h604 + 30'(i), 32'h13, 1'b0, 1'b0);
      chk("wrap_pc",    ibuf_pc,    30'h601 + 30'(i));
      chk("wrap_count", ibuf_count, 4);
      chk("wrap_ovf",   ibuf_overflow, 0);
    end
    repeat (4) idle(1'b0);

    // Pre-decode hints
    cycle(1'b1, 1'b0, 30'h700, 32'hFE000EE3, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 30'h701, 32'h0080006F, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 30'h702, 32'h0080006F, 1'b0, 1'b1);
    chk("beq_br",  ibuf_br_back, 1);
    chk("beq_jal", ibuf_jal, 0);
    idle(1'b0);
    chk("jal_jal", ibuf_jal, 1);
    chk("jal_br",  ibuf_br_back, 0);
    idle(1'b0);
    chk("exc_exc", ibuf_exc, 1);
    chk("exc_br",  ibuf_br_back, 0);
    chk("exc_jal", ibuf_jal, 0);
    idle(1'b0);

    // Empty-buffer latency
    fe1_valid = 1'b1; fe1_exc = 1'b0; fe1_pc = 30'h800; fe1_insn = 32'h13;
    flush = 1'b0; de_stall = 1'b0;
    #3;
`ifdef DECODE_IBUF_BYPASS_EN
    chk("byp_valid", ibuf_valid, 1);
    chk("byp_pc",    ibuf_pc, 30'h800);
    chk("byp_count", ibuf_count, 0);
    @(posedge clk_core); #1;
    fe1_valid = 1'b0; de_stall = 1'b1;
    #3;
    chk("byp_after_valid", ibuf_valid, 0);
    chk("byp_after_count", ibuf_count, 0);
`else
    chk("lat_valid", ibuf_valid, 0);
    chk("lat_count", ibuf_count, 0);
    exp_q.push_back({1'b0, 30'h800, 32'h13});
    @(posedge clk_core); #1;
    fe1_valid = 1'b0; de_stall = 1'b1;
    #3;
    chk("lat_next_valid", ibuf_valid, 1);
    chk("lat_next_pc",    ibuf_pc, 30'h800);
    chk("lat_next_count", ibuf_count, 1);
`endif
    @(posedge clk_core); #1;
    idle(1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] insn;
      insn = $urandom;
      case ($urandom_range(0, 3))
        0: insn[6:0] = 7'h63;
        1: insn[6:0] = 7'h6F;
        2: insn[6:0] = 7'h13;
        default: ;
      endcase
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10, 30'($urandom), insn,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
